// File: rtl/mips_avalon_pkg.sv
// Shared definitions for the MIPS CPU and its Avalon-MM memory responder:
// transfer FSM states, reset vector, out-of-range fill pattern and LFSR constants.
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_VECTOR     = 32'hBFC00000;
  localparam logic [31:0] OOR_DATA_DEFAULT = 32'hDEADBEEF;

  // Fibonacci LFSR, taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/avalon_wait_lfsr.sv
// Pseudo-random source for per-request wait counts; only instantiated by
// avalon_slave_ram when AVALON_SLAVE_RAM_RANDOM_WAIT_EN is defined.
module avalon_wait_lfsr
  import mips_avalon_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/avalon_slave_ram.sv
// Avalon-MM word RAM responder with wait-state insertion and bus_error reporting.
// Define AVALON_SLAVE_RAM_RANDOM_WAIT_EN for LFSR-randomised wait counts.
module avalon_slave_ram
  import mips_avalon_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] OOR_DATA    = OOR_DATA_DEFAULT
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        bus_error,
  output state_t      dbg_state_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

  // Handshake: a request (read|write) is held by the master while waitrequest=1;
  // the single cycle with request high and waitrequest=0 completes it.
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              bus_error_q, bus_error_d;
  logic              enter_ack;
  logic              req;
  logic [31:0]       off;
  logic              in_range;
  logic              misaligned;
  logic [IDX_W-1:0]  idx;
  logic              mem_we;
  logic [3:0]        wait_cnt;
  logic [31:0]       mem_q [DEPTH];

  assign req        = read | write;
  assign off        = address - BASE_ADDR;
  assign in_range   = (address >= BASE_ADDR) && (off < SPAN);
  assign misaligned = (address[1:0] != 2'b00);
  assign idx        = off[IDX_W+1:2];

`ifdef AVALON_SLAVE_RAM_RANDOM_WAIT_EN
  logic [15:0] lfsr_value;
  logic        lfsr_advance;

  assign lfsr_advance = reset && (state_q == IDLE) && req;
  assign wait_cnt     = 4'(32'(lfsr_value[3:0]) % (WAIT_CYCLES + 1));

  avalon_wait_lfsr u_wait_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (lfsr_advance),
    .value   (lfsr_value)
  );
`else
  assign wait_cnt = 4'(WAIT_CYCLES);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    readdata_d  = readdata_q;
    bus_error_d = 1'b0;
    enter_ack   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (wait_cnt == 4'd0) begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_cnt;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          // Master abandoned the request: abort without touching memory.
          state_d     = IDLE;
          cnt_d       = 4'd0;
          bus_error_d = 1'b1;
        end else if (cnt_q <= 4'd1) begin
          state_d   = ACK;
          cnt_d     = 4'd0;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_ack) begin
      readdata_d  = in_range ? mem_q[idx] : OOR_DATA;
      bus_error_d = (read && write) || !in_range || misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      readdata_q  <= 32'd0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      readdata_q  <= readdata_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Writes land on the ACK edge; simultaneous read wins and suppresses the write.
  assign mem_we = reset && (state_q == ACK) && write && !read && in_range;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) mem_q[idx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  assign waitrequest = req && (!reset || (state_q != ACK));
  assign readdata    = readdata_q;
  assign bus_error   = bus_error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_avalon_slave_ram.sv
// Directed bench for avalon_slave_ram: three instances (WAIT_CYCLES 1/0/3) share
// one request bus; instance 0 carries the data checks against a word model.
module tb_avalon_slave_ram;
  import mips_avalon_pkg::*;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 1024;
  localparam int          BOUND = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] rdata [3];
  logic        wreq  [3];
  logic        berr  [3];
  state_t      st    [3];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mdl [int];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  avalon_slave_ram #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(1), .OOR_DATA(32'hDEADBEEF)) u_dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(rdata[0]),
    .waitrequest(wreq[0]), .bus_error(berr[0]), .dbg_state_o(st[0]));

  avalon_slave_ram #(.BASE_ADDR(BASE), .DEPTH(16), .WAIT_CYCLES(0), .OOR_DATA(32'hDEADBEEF)) u_wc0 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(rdata[1]),
    .waitrequest(wreq[1]), .bus_error(berr[1]), .dbg_state_o(st[1]));

  avalon_slave_ram #(.BASE_ADDR(BASE), .DEPTH(16), .WAIT_CYCLES(3), .OOR_DATA(32'hDEADBEEF)) u_wc3 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(rdata[2]),
    .waitrequest(wreq[2]), .bus_error(berr[2]), .dbg_state_o(st[2]));

  // ---------------- model / scoreboard ----------------
  function automatic logic in_rng(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    if (!in_rng(a)) return 32'hDEADBEEF;
    if (mdl.exists(widx(a))) return mdl[widx(a)];
    return 32'hxxxxxxxx;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic xfer(input int sel, input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] data, input logic exp_err,
                      input int exp_waits, input string tag);
    int waits;
    logic [31:0] word;
    @(negedge clk);
    read = rd; write = wr; address = addr; byteenable = be; writedata = data;
    if (rd && sel == 0) exp_q.push_back(mdl_rd(addr));
    waits = 0;
    #1;
    while (wreq[sel] === 1'b1 && waits < BOUND) begin
      waits++;
      @(negedge clk);
      #1;
    end
    check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
    check({tag, "_berr"}, 32'(berr[sel]), 32'(exp_err));
    if (rd && sel == 0) check({tag, "_rdata"}, rdata[0], exp_q.pop_front());
    if (sel == 0 && wr && !rd && in_rng(addr)) begin
      word = mdl.exists(widx(addr)) ? mdl[widx(addr)] : 32'h0;
      for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = data[8*b +: 8];
      mdl[widx(addr)] = word;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      read = 1'b0; write = 1'b0;
    end
  endtask

  task automatic idle_berr_clear(input string tag);
    idle(1);
    #1;
    check({tag, "_berr_clear"}, 32'(berr[0]), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0;
    address = 32'h0; byteenable = 4'h0; writedata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rdata", rdata[0], 32'h0);
    check("rst_berr", 32'(berr[0]), 32'd0);
    check("rst_wreq_idle", 32'(wreq[0]), 32'd0);
    check("rst_state", 32'(st[0]), 32'(IDLE));
    read = 1'b1; address = BASE;
    #1;
    check("rst_wreq_req", 32'(wreq[0]), 32'd1);
    @(negedge clk); #1;
    check("rst_wreq_held", 32'(wreq[0]), 32'd1);
    check("rst_state_held", 32'(st[0]), 32'(IDLE));
    read = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // aligned write/read and byte lanes
    xfer(0, 1'b0, 1'b1, 32'hBFC00010, 4'hF, 32'h12345678, 1'b0, 2, "wr_full");
    xfer(0, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 1'b0, 2, "rd_full");
    idle(1);
    xfer(0, 1'b0, 1'b1, 32'hBFC00010, 4'b0101, 32'hAABBCCDD, 1'b0, 2, "wr_lanes");
    xfer(0, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 1'b0, 2, "rd_lanes");
    check("lanes_const", mdl_rd(32'hBFC00010), 32'h12BB56DD);
    idle(2);

    // wait-state variants, back-to-back
    xfer(1, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 1'b0, 1, "wc0_rd_a");
    xfer(1, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 1'b0, 1, "wc0_rd_b");
    idle(2);
    xfer(2, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 1'b0, 4, "wc3_rd_a");
    xfer(2, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 1'b0, 4, "wc3_rd_b");
    idle(3);

    // out of range
    xfer(0, 1'b0, 1'b1, BASE, 4'hF, 32'hCAFEF00D, 1'b0, 2, "wr_word0");
    idle(1);
    xfer(0, 1'b1, 1'b0, 32'h00000000, 4'hF, 32'h0, 1'b1, 2, "oor_rd");
    idle_berr_clear("oor_rd");
    xfer(0, 1'b0, 1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'h0BADBAD0, 1'b1, 2, "oor_wr");
    idle_berr_clear("oor_wr");
    xfer(0, 1'b1, 1'b0, BASE, 4'hF, 32'h0, 1'b0, 2, "rd_word0");
    idle(1);

    // read and write together, misaligned, empty byteenable
    xfer(0, 1'b1, 1'b1, 32'hBFC00010, 4'hF, 32'h55555555, 1'b1, 2, "rdwr");
    idle_berr_clear("rdwr");
    xfer(0, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 1'b0, 2, "rdwr_after");
    idle(1);
    xfer(0, 1'b1, 1'b0, 32'hBFC00013, 4'hF, 32'h0, 1'b1, 2, "misalign");
    idle(1);
    xfer(0, 1'b0, 1'b1, 32'hBFC00010, 4'h0, 32'hFFFFFFFF, 1'b0, 2, "be_zero");
    xfer(0, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 1'b0, 2, "be_zero_rd");
    idle(2);

    // read dropped during WAIT
    @(negedge clk);
    read = 1'b1; address = 32'hBFC00010; byteenable = 4'hF;
    #1;
    check("drop_req_state", 32'(st[0]), 32'(IDLE));
    @(negedge clk);
    read = 1'b0;
    #1;
    check("drop_wait_state", 32'(st[0]), 32'(WAIT));
    @(negedge clk); #1;
    check("drop_idle", 32'(st[0]), 32'(IDLE));
    check("drop_berr", 32'(berr[0]), 32'd1);
    @(negedge clk); #1;
    check("drop_berr_clear", 32'(berr[0]), 32'd0);

    // reset in the middle of a write
    xfer(0, 1'b0, 1'b1, 32'hBFC00020, 4'hF, 32'h11111111, 1'b0, 2, "pre_rst_wr");
    idle(1);
    @(negedge clk);
    write = 1'b1; address = 32'hBFC00020; byteenable = 4'hF; writedata = 32'h99999999;
    @(negedge clk);
    #1;
    check("mid_rst_wait", 32'(st[0]), 32'(WAIT));
    reset = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_wreq", 32'(wreq[0]), 32'd1);
    check("mid_rst_rdata", rdata[0], 32'h0);
    check("mid_rst_state", 32'(st[0]), 32'(IDLE));
    @(negedge clk);
    write = 1'b0;
    reset = 1'b1;
    xfer(0, 1'b1, 1'b0, 32'hBFC00020, 4'hF, 32'h0, 1'b0, 2, "post_rst_rd");
    idle(1);
    xfer(0, 1'b0, 1'b1, 32'hBFC00024, 4'hF, 32'h0F1E2D3C, 1'b0, 2, "post_rst_wr2");
    xfer(0, 1'b1, 1'b0, 32'hBFC00024, 4'hF, 32'h0, 1'b0, 2, "post_rst_rd2");
    idle(2);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
